// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, reads 16-bit words from instruction memory and queues {instr, pc} for decode.
// Define IFQ_BYPASS_EN to forward an acked word straight to decode when the queue is empty.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  output logic                     imem_req,
  output logic [15:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [15:0]              imem_rdata,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [15:0]              instr,
  output logic [15:0]              instr_pc,
  input  logic                     redirect_valid,
  input  logic [15:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [15:0]   START_PC = RESET_PC & 16'hFFFE;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

  state_e         state_q, state_d;
  logic [15:0]    addr_q, addr_d;
  logic [15:0]    fetchPc_q, fetchPc_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  head_q, tail_q;
  logic [15:0]    memInstr_q [DEPTH];
  logic [15:0]    memPc_q [DEPTH];

  logic [15:0]    redirTarget;
  logic           ackHit, doPush, doPop, bypassTake, space;

  assign redirTarget = redirect_pc & 16'hFFFE;
  assign ackHit      = (state_q == REQ) && imem_ack && !redirect_valid;
  assign doPush      = ackHit && !bypassTake;
  assign doPop       = !redirect_valid && (count_q != '0) && instr_ready;

`ifdef IFQ_BYPASS_EN
  logic bypassHit;
  assign bypassHit   = ackHit && (count_q == '0);
  assign bypassTake  = bypassHit && instr_ready;
  assign instr_valid = (count_q != '0) || bypassHit;
  assign instr       = bypassHit ? imem_rdata : memInstr_q[head_q];
  assign instr_pc    = bypassHit ? addr_q : memPc_q[head_q];
`else
  assign bypassTake  = 1'b0;
  assign instr_valid = (count_q != '0);
  assign instr       = memInstr_q[head_q];
  assign instr_pc    = memPc_q[head_q];
`endif

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = addr_q;
  assign q_count   = count_q;

  // A new request is only issued when the post-edge occupancy leaves a slot for its data.
  always_comb begin
    count_d   = redirect_valid ? '0 : count_q + CW'(doPush) - CW'(doPop);
    fetchPc_d = redirect_valid ? redirTarget : (ackHit ? fetchPc_q + 16'd2 : fetchPc_q);
    space     = (count_d < DEPTH_C);
    state_d   = state_q;
    addr_d    = addr_q;
    case (state_q)
      IDLE: begin
        if (space) begin
          state_d = REQ;
          addr_d  = fetchPc_d;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (space) begin
            addr_d = fetchPc_d;
          end else begin
            state_d = IDLE;
          end
        end else if (redirect_valid) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          state_d = REQ;
          addr_d  = fetchPc_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= START_PC;
      fetchPc_q <= START_PC;
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      fetchPc_q <= fetchPc_d;
      count_q   <= count_d;
      if (redirect_valid) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (doPush) tail_q <= tail_q + PW'(1);
        if (doPop)  head_q <= head_q + PW'(1);
      end
    end
  end

  // Entries are cleared on reset so instr/instr_pc read zero before the first fetch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        memInstr_q[i] <= '0;
        memPc_q[i]    <= '0;
      end
    end else if (doPush) begin
      memInstr_q[tail_q] <= imem_rdata;
      memPc_q[tail_q]    <= addr_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue with a zero-wait and a 2-cycle memory model.
module tb_instr_fetch_queue;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req, imem_ack, instr_valid, instr_ready, redirect_valid;
  logic [15:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
  logic [2:0]  q_count;
  logic        memMode = 1'b0;
  logic [1:0]  latCnt = '0;
  int          ackCount = 0;
  int          checkCount = 0;
  int          failCount = 0;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(16'h0)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .q_count(q_count)
  );

  always #5 clock = ~clock;

  // Memory returns addr>>1; mode 0 acks in the request cycle, mode 1 on the second cycle.
  assign imem_rdata = imem_addr >> 1;
  assign imem_ack   = memMode ? (imem_req && latCnt == 2'd1) : imem_req;

  always @(posedge clock) begin
    if (!imem_req || imem_ack) latCnt <= '0;
    else latCnt <= latCnt + 2'd1;
    if (imem_ack && reset_n) ackCount <= ackCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic mode, input logic rdy);
    @(negedge clock);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    memMode        = mode;
    instr_ready    = rdy;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic waitValid(input string tag, input logic [15:0] expPc);
    logic found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (instr_valid) found = 1'b1;
      else step(1);
    end
    checkOutput({tag, "_seen"}, found, 1);
    if (found) begin
      checkOutput({tag, "_pc"}, instr_pc, expPc);
      checkOutput({tag, "_instr"}, instr, expPc >> 1);
    end
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int snap;
    int idx;
    logic [15:0] exp5 [3];
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #12;
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_addr", imem_addr, 0);
    checkOutput("rst_valid", instr_valid, 0);
    checkOutput("rst_instr", instr, 0);
    checkOutput("rst_pc", instr_pc, 0);
    checkOutput("rst_count", q_count, 0);

    // Zero-wait memory, decode always ready: one fetch per cycle.
    applyStimulus(1'b0, 1'b1);
    step(1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t1_req", imem_req, 1);
      checkOutput("t1_addr", imem_addr, 2 * k);
`ifdef IFQ_BYPASS_EN
      checkOutput("t1_valid", instr_valid, 1);
      checkOutput("t1_instr", instr, k);
      checkOutput("t1_pc", instr_pc, 2 * k);
      checkOutput("t1_count", q_count, 0);
`else
      if (k >= 1) begin
        checkOutput("t1_valid", instr_valid, 1);
        checkOutput("t1_instr", instr, k - 1);
        checkOutput("t1_pc", instr_pc, 2 * (k - 1));
        checkOutput("t1_count", q_count, 1);
      end else begin
        checkOutput("t1_valid0", instr_valid, 0);
      end
`endif
      step(1);
    end

    // Decode stalled: queue fills to DEPTH and requests stop.
    applyStimulus(1'b0, 1'b0);
    snap = ackCount;
    step(8);
    checkOutput("t2_acks", ackCount - snap, 4);
    checkOutput("t2_req", imem_req, 0);
    checkOutput("t2_count", q_count, 4);
    checkOutput("t2_head", instr_pc, 0);
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    checkOutput("t2_count_pop", q_count, 3);
    checkOutput("t2_req_again", imem_req, 1);
    checkOutput("t2_addr", imem_addr, 16'h0008);
    checkOutput("t2_head_pop", instr_pc, 2);

    // Redirect while a 2-cycle read is outstanding.
    applyStimulus(1'b1, 1'b1);
    step(3);
    checkOutput("t3_addr_pre", imem_addr, 2);
    checkOutput("t3_ack_pre", imem_ack, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0041;
    step(1);
    redirect_valid = 1'b0;
    checkOutput("t3_req_held", imem_req, 1);
    checkOutput("t3_addr_held", imem_addr, 2);
    checkOutput("t3_valid_flush", instr_valid, 0);
    checkOutput("t3_count_flush", q_count, 0);
    step(1);
    checkOutput("t3_addr_new", imem_addr, 16'h0040);
    checkOutput("t3_valid_drop", instr_valid, 0);
    waitValid("t3_first", 16'h0040);

    // Redirect coincides with an ack while two entries are queued.
    applyStimulus(1'b1, 1'b0);
    step(5);
    checkOutput("t4_count2", q_count, 2);
    checkOutput("t4_ack_pre", imem_ack, 0);
    step(1);
    checkOutput("t4_ack", imem_ack, 1);
    checkOutput("t4_addr_pre", imem_addr, 4);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    instr_ready    = 1'b1;
    step(1);
    redirect_valid = 1'b0;
    checkOutput("t4_count0", q_count, 0);
    checkOutput("t4_valid0", instr_valid, 0);
    checkOutput("t4_req", imem_req, 1);
    checkOutput("t4_addr", imem_addr, 16'h0100);
    waitValid("t4_first", 16'h0100);

    // PC wrap through 16'hFFFE.
    applyStimulus(1'b0, 1'b1);
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFC;
    step(1);
    redirect_valid = 1'b0;
    checkOutput("t5_addr", imem_addr, 16'hFFFC);
    exp5 = '{16'hFFFC, 16'hFFFE, 16'h0000};
    idx  = 0;
    for (int i = 0; i < 12; i++) begin
      if (instr_valid && idx < 3) begin
        checkOutput("t5_pc", instr_pc, exp5[idx]);
        idx++;
      end
      step(1);
    end
    checkOutput("t5_seen", idx, 3);

    // Latency from ack to decode with an empty queue.
    applyStimulus(1'b1, 1'b1);
    step(2);
    checkOutput("t6_ack", imem_ack, 1);
`ifdef IFQ_BYPASS_EN
    checkOutput("t6_valid_ack", instr_valid, 1);
    checkOutput("t6_pc_ack", instr_pc, 0);
    checkOutput("t6_count_ack", q_count, 0);
    step(1);
    checkOutput("t6_count_next", q_count, 0);
`else
    checkOutput("t6_valid_ack", instr_valid, 0);
    checkOutput("t6_count_ack", q_count, 0);
    step(1);
    checkOutput("t6_valid_next", instr_valid, 1);
    checkOutput("t6_count_next", q_count, 1);
    checkOutput("t6_pc_next", instr_pc, 0);
`endif
    step(1);
    checkOutput("t6_count_drain", q_count, 0);

    // Reset asserted between edges clears outputs immediately.
    checkOutput("ar_req_pre", imem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("ar_req", imem_req, 0);
    checkOutput("ar_addr", imem_addr, 0);
    checkOutput("ar_count", q_count, 0);
    checkOutput("ar_valid", instr_valid, 0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
